// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared opcodes, reorder-buffer entry type and opcode decode helpers
package tomasulo_pkg;

   localparam int ROB_IDX_W   = 3;
   localparam int ROB_DATA_W  = 16;
   localparam int ROB_REG_W   = 4;
   localparam int ROB_FUNC_W  = 4;

   localparam logic [ROB_FUNC_W-1:0] FUNC_ADD = 4'b0000;
   localparam logic [ROB_FUNC_W-1:0] FUNC_SUB = 4'b0001;
   localparam logic [ROB_FUNC_W-1:0] FUNC_MUL = 4'b0010;
   localparam logic [ROB_FUNC_W-1:0] FUNC_DIV = 4'b0011;

   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic [ROB_FUNC_W-1:0] func;
      logic [ROB_REG_W-1:0]  rd;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry_t;

   // Adder-class opcodes free an add reservation station on retirement.
   function automatic logic is_add_func(input logic [ROB_FUNC_W-1:0] f);
      return (f == FUNC_ADD) || (f == FUNC_SUB);
   endfunction

   // Multiplier-class opcodes free a mul reservation station on retirement.
   function automatic logic is_mul_func(input logic [ROB_FUNC_W-1:0] f);
      return (f == FUNC_MUL) || (f == FUNC_DIV);
   endfunction

endpackage

// File: rtl/rob_storage.sv
// rtl/rob_storage.sv - reorder-buffer entry array with alloc, writeback and head-clear write ports
// Ports: clk1/rst_n/flush clear all valid bits; alloc_* writes a fresh entry;
//        wb_* completes a valid, not-yet-ready entry; clr_* retires an entry;
//        head_idx/head_entry is the combinational head read port.
module rob_storage
   import tomasulo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3
) (
   input  logic                  clk1,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  alloc_en,
   input  logic [IDX_W-1:0]      alloc_idx,
   input  logic [ROB_FUNC_W-1:0] alloc_func,
   input  logic [ROB_REG_W-1:0]  alloc_rd,
   input  logic                  wb_en,
   input  logic [IDX_W-1:0]      wb_idx,
   input  logic [ROB_DATA_W-1:0] wb_data,
   input  logic                  clr_en,
   input  logic [IDX_W-1:0]      clr_idx,
   input  logic [IDX_W-1:0]      head_idx,
   output rob_entry_t            head_entry
);

   rob_entry_t mem_q [DEPTH];

   always_ff @(posedge clk1) begin
      if (!rst_n || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i].valid <= 1'b0;
            mem_q[i].ready <= 1'b0;
         end
      end else begin
         // First result wins: a ready entry ignores later broadcasts, and an
         // invalid (unallocated) entry ignores them too.
         if (wb_en && mem_q[wb_idx].valid && !mem_q[wb_idx].ready) begin
            mem_q[wb_idx].ready <= 1'b1;
            mem_q[wb_idx].data  <= wb_data;
         end
         if (alloc_en) begin
            mem_q[alloc_idx].valid <= 1'b1;
            mem_q[alloc_idx].ready <= 1'b0;
            mem_q[alloc_idx].func  <= alloc_func;
            mem_q[alloc_idx].rd    <= alloc_rd;
         end
         // Placed last so a bypassed commit overrides the same-edge writeback.
         if (clr_en) begin
            mem_q[clr_idx].valid <= 1'b0;
            mem_q[clr_idx].ready <= 1'b0;
         end
      end
   end

   assign head_entry = mem_q[head_idx];

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with in-order commit; optional ROB_WB_BYPASS_EN head bypass
// Ports: alloc_* issue-side allocation (alloc_tag = tail index); wb_* CDB broadcast;
//        flush discards all entries; commit_* / free_* registered one-cycle retirement;
//        rob_count occupancy. Define ROB_WB_BYPASS_EN to commit the head on its own wb edge.
module rob_commit
   import tomasulo_pkg::*;
#(
   parameter int ROB_DEPTH = 8,
   parameter int DATA_W    = ROB_DATA_W,
   parameter int REG_W     = ROB_REG_W,
   parameter int FUNC_W    = ROB_FUNC_W,
   localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [FUNC_W-1:0] alloc_func,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic [IDX_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              commit_valid,
   output logic [IDX_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [FUNC_W-1:0] commit_func,
   output logic              free_add,
   output logic              free_mul,
   output logic [IDX_W:0]    rob_count
);

   localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

   logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
   logic              full, do_alloc, do_commit, bypass_hit;
   logic [DATA_W-1:0] commit_data_d;
   rob_entry_t        head_e;

   logic              commit_valid_q, free_add_q, free_mul_q;
   logic [IDX_W-1:0]  commit_tag_q;
   logic [REG_W-1:0]  commit_rd_q;
   logic [DATA_W-1:0] commit_data_q;
   logic [FUNC_W-1:0] commit_func_q;

   // Full when indices match but the wrap bits differ.
   assign full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
   assign alloc_ready = !full;
   assign alloc_tag   = tail_q[IDX_W-1:0];
   assign rob_count   = tail_q - head_q;
   assign do_alloc    = alloc_valid && alloc_ready;

`ifdef ROB_WB_BYPASS_EN
   assign bypass_hit = wb_valid && (wb_tag == head_q[IDX_W-1:0]) && head_e.valid && !head_e.ready;
`else
   assign bypass_hit = 1'b0;
`endif

   assign do_commit     = head_e.valid && (head_e.ready || bypass_hit);
   assign commit_data_d = bypass_hit ? wb_data : head_e.data;

   rob_storage #(
      .DEPTH (ROB_DEPTH),
      .IDX_W (IDX_W)
   ) u_storage (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc_en   (do_alloc),
      .alloc_idx  (tail_q[IDX_W-1:0]),
      .alloc_func (alloc_func),
      .alloc_rd   (alloc_rd),
      .wb_en      (wb_valid),
      .wb_idx     (wb_tag),
      .wb_data    (wb_data),
      .clr_en     (do_commit),
      .clr_idx    (head_q[IDX_W-1:0]),
      .head_idx   (head_q[IDX_W-1:0]),
      .head_entry (head_e)
   );

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (do_commit) head_d = head_q + PTR_ONE;
      if (do_alloc)  tail_d = tail_q + PTR_ONE;
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         head_q         <= '0;
         tail_q         <= '0;
         commit_valid_q <= 1'b0;
         free_add_q     <= 1'b0;
         free_mul_q     <= 1'b0;
         commit_tag_q   <= '0;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
         commit_func_q  <= '0;
      end else if (flush) begin
         // Retirement fields keep their last value; only the pulses drop.
         head_q         <= '0;
         tail_q         <= '0;
         commit_valid_q <= 1'b0;
         free_add_q     <= 1'b0;
         free_mul_q     <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         commit_valid_q <= do_commit;
         free_add_q     <= do_commit && is_add_func(head_e.func);
         free_mul_q     <= do_commit && is_mul_func(head_e.func);
         if (do_commit) begin
            commit_tag_q  <= head_q[IDX_W-1:0];
            commit_rd_q   <= head_e.rd;
            commit_data_q <= commit_data_d;
            commit_func_q <= head_e.func;
         end
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_tag   = commit_tag_q;
   assign commit_rd    = commit_rd_q;
   assign commit_data  = commit_data_q;
   assign commit_func  = commit_func_q;
   assign free_add     = free_add_q;
   assign free_mul     = free_mul_q;

endmodule
